// File: rtl/systolic_skew_buf.sv
// systolic_skew_buf: per-lane delay lines that skew (MODE 0) or de-skew (MODE 1) DIM-wide rows.
// Define SKEW_BUF_STATS_EN to add saturating rows_in/rows_out counters.
module systolic_skew_buf #(
    parameter int BITS_AB      = 8,
    parameter int DIM          = 8,
    parameter int MODE         = 0,
    parameter int ZERO_INVALID = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic signed [BITS_AB-1:0] din [DIM-1:0],
    input  logic                      flush,
    output logic signed [BITS_AB-1:0] dout [DIM-1:0],
    output logic [DIM-1:0]            dout_vld,
    output logic                      busy,
`ifdef SKEW_BUF_STATS_EN
    output logic                      done,
    output logic [15:0]               rows_in,
    output logic [15:0]               rows_out
`else
    output logic                      done
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    logic   done_q;

    logic [DIM-1:0]            lane_any_q;
    logic [DIM-1:0]            lane_any_d;
    logic [DIM-1:0]            last_vld_q;
    logic signed [BITS_AB-1:0] last_dat_q [DIM];
    logic                      any_d;

`ifdef SKEW_BUF_STATS_EN
    localparam int LONG = (MODE == 0) ? DIM - 1 : 0;
    logic long_vld_d;
`endif

    for (genvar c = 0; c < DIM; c++) begin : g_lane
        localparam int D = (MODE == 0) ? c + 1 : DIM - c;

        logic signed [BITS_AB-1:0] dat_q [D];
        logic signed [BITS_AB-1:0] dat_d [D];
        logic [D-1:0]              vld_q;
        logic [D-1:0]              vld_d;

        // Bubbles enter with zero data so invalid stages never carry stale values.
        always_comb begin
            vld_d[0] = in_valid;
            dat_d[0] = in_valid ? din[c] : '0;
            for (int s = 1; s < D; s++) begin
                vld_d[s] = vld_q[s-1];
                dat_d[s] = dat_q[s-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                vld_q <= '0;
                for (int s = 0; s < D; s++) begin
                    dat_q[s] <= '0;
                end
            end else if (en) begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign lane_any_q[c] = |vld_q;
        assign lane_any_d[c] = |vld_d;
        assign last_vld_q[c] = vld_q[D-1];
        assign last_dat_q[c] = dat_q[D-1];

`ifdef SKEW_BUF_STATS_EN
        if (c == LONG) begin : g_long
            assign long_vld_d = vld_d[D-1];
        end
`endif
    end

    assign any_d = |lane_any_d;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else if (!en) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) state_q <= RUN;
                end
                RUN: begin
                    if (!in_valid) begin
                        if (any_d) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        state_q <= RUN;
                    end else if (!any_d) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            if ((ZERO_INVALID != 0) && !last_vld_q[c]) begin
                dout[c] = '0;
            end else begin
                dout[c] = last_dat_q[c];
            end
        end
    end

    assign dout_vld = last_vld_q;
    assign busy     = |lane_any_q;
    assign done     = done_q;

`ifdef SKEW_BUF_STATS_EN
    logic [15:0] rows_in_q;
    logic [15:0] rows_out_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rows_in_q  <= '0;
            rows_out_q <= '0;
        end else if (en) begin
            if (in_valid && (rows_in_q != 16'hFFFF)) begin
                rows_in_q <= rows_in_q + 16'd1;
            end
            if (long_vld_d && (rows_out_q != 16'hFFFF)) begin
                rows_out_q <= rows_out_q + 16'd1;
            end
        end
    end

    assign rows_in  = rows_in_q;
    assign rows_out = rows_out_q;
`endif

endmodule

// File: tb/tb_systolic_skew_buf.sv
// Directed bench for systolic_skew_buf: DIM=4 skew instance driven from a vector
// table, plus a de-skew instance and counter checks in hand-written sequences.
module tb_systolic_skew_buf;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic              flush;
    logic signed [7:0] din   [3:0];
    logic signed [7:0] dout0 [3:0];
    logic signed [7:0] dout1 [3:0];
    logic [3:0]        vld0, vld1;
    logic              busy0, busy1, done0, done1;
    logic [31:0]       dout0_w, dout1_w;
`ifdef SKEW_BUF_STATS_EN
    logic [15:0]       rin0, rout0, rin1, rout1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_skew_buf #(.BITS_AB(8), .DIM(4), .MODE(0), .ZERO_INVALID(1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .din(din),
        .flush(flush), .dout(dout0), .dout_vld(vld0), .busy(busy0),
`ifdef SKEW_BUF_STATS_EN
        .done(done0), .rows_in(rin0), .rows_out(rout0)
`else
        .done(done0)
`endif
    );

    systolic_skew_buf #(.BITS_AB(8), .DIM(4), .MODE(1), .ZERO_INVALID(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .din(din),
        .flush(flush), .dout(dout1), .dout_vld(vld1), .busy(busy1),
`ifdef SKEW_BUF_STATS_EN
        .done(done1), .rows_in(rin1), .rows_out(rout1)
`else
        .done(done1)
`endif
    );

    assign dout0_w = {dout0[3], dout0[2], dout0[1], dout0[0]};
    assign dout1_w = {dout1[3], dout1[2], dout1[1], dout1[0]};

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        fl;
        logic        iv;
        logic [31:0] din;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic        eb;
        logic        edn;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, input logic e, input logic f,
                                input logic iv, input logic [31:0] d,
                                input logic [3:0] ev, input logic [31:0] ed,
                                input logic eb, input logic edn);
        vec_t v;
        v.rst = r; v.en = e; v.fl = f; v.iv = iv; v.din = d;
        v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w);
        for (int c = 0; c < 4; c++) din[c] = w[8*c +: 8];
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rst = tv[i].rst; en = tv[i].en; flush = tv[i].fl;
            in_valid = tv[i].iv; drive(tv[i].din);
            @(posedge clk); #1;
            chk($sformatf("v%0d_dout", i), dout0_w, tv[i].ed);
            chk($sformatf("v%0d_vld", i), {28'd0, vld0}, {28'd0, tv[i].ev});
            chk($sformatf("v%0d_busy", i), {31'd0, busy0}, {31'd0, tv[i].eb});
            chk($sformatf("v%0d_done", i), {31'd0, done0}, {31'd0, tv[i].edn});
        end
    endtask

    int s_main, s_stall, s_bub, s_fl, s_rd, s_rd2, s_end;

    logic [3:0]  m1_ev [8];
    logic [31:0] xw;

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; drive(32'd0);

        tv.push_back(mk(1,1,0,0,32'd0,4'b0000,32'd0,0,0));
        tv.push_back(mk(1,1,0,0,32'd0,4'b0000,32'd0,0,0));

        s_main = tv.size();
        tv.push_back(mk(0,1,0,1,32'h04030201,4'b0001,32'h00000001,1,0));
        tv.push_back(mk(0,1,0,1,32'h08070605,4'b0011,32'h00000205,1,0));
        tv.push_back(mk(0,1,0,1,32'h0C0B0A09,4'b0111,32'h00030609,1,0));
        tv.push_back(mk(0,1,0,1,32'h100F0E0D,4'b1111,32'h04070A0D,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1110,32'h080B0E00,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1100,32'h0C0F0000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1000,32'h10000000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,1));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,0));

        s_stall = tv.size();
        tv.push_back(mk(0,1,0,1,32'h00FF7F80,4'b0001,32'h00000080,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0010,32'h00007F00,1,0));
        for (int k = 0; k < 5; k++)
            tv.push_back(mk(0,0,0,1,32'hAAAAAAAA,4'b0010,32'h00007F00,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0100,32'h00FF0000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1000,32'h00000000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,1));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,0));

        s_bub = tv.size();
        tv.push_back(mk(0,1,0,1,32'h04030201,4'b0001,32'h00000001,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0010,32'h00000200,1,0));
        tv.push_back(mk(0,1,0,1,32'h08070605,4'b0101,32'h00030005,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1010,32'h04000600,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0100,32'h00070000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1000,32'h08000000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,1));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,0));

        s_fl = tv.size();
        tv.push_back(mk(0,1,0,1,32'h04030201,4'b0001,32'h00000001,1,0));
        tv.push_back(mk(0,1,0,1,32'h08070605,4'b0011,32'h00000205,1,0));
        tv.push_back(mk(0,1,0,1,32'h0C0B0A09,4'b0111,32'h00030609,1,0));
        tv.push_back(mk(0,0,1,1,32'h100F0E0D,4'b0000,32'd0,0,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,0));
        tv.push_back(mk(0,1,0,1,32'h18171615,4'b0001,32'h00000015,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0010,32'h00001600,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0100,32'h00170000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1000,32'h18000000,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,1));
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,0));

        s_rd = tv.size();
        tv.push_back(mk(0,1,0,1,32'h04030201,4'b0001,32'h00000001,1,0));
        tv.push_back(mk(0,1,0,1,32'h08070605,4'b0011,32'h00000205,1,0));
        tv.push_back(mk(0,1,0,1,32'h0C0B0A09,4'b0111,32'h00030609,1,0));
        tv.push_back(mk(0,1,0,1,32'h100F0E0D,4'b1111,32'h04070A0D,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1110,32'h080B0E00,1,0));
        tv.push_back(mk(0,1,0,0,32'd0,4'b1100,32'h0C0F0000,1,0));
        tv.push_back(mk(1,0,0,0,32'd0,4'b0000,32'd0,0,0));
        s_rd2 = tv.size();
        tv.push_back(mk(0,1,0,0,32'd0,4'b0000,32'd0,0,0));
        s_end = tv.size();

        run(0, s_main);
`ifdef SKEW_BUF_STATS_EN
        chk("stats_rst_in", {16'd0, rin0}, 32'd0);
        chk("stats_rst_out", {16'd0, rout0}, 32'd0);
`endif
        run(s_main, s_stall);
`ifdef SKEW_BUF_STATS_EN
        chk("stats_run_in", {16'd0, rin0}, 32'd4);
        chk("stats_run_out", {16'd0, rout0}, 32'd4);
`endif
        run(s_stall, s_rd2);
`ifdef SKEW_BUF_STATS_EN
        chk("stats_midrst_in", {16'd0, rin0}, 32'd0);
        chk("stats_midrst_out", {16'd0, rout0}, 32'd0);
`endif
        run(s_rd2, s_end);

        // De-skew: lane c's element arrives c edges late, all lanes align after edge 3.
        m1_ev = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                  4'b0111, 4'b0011, 4'b0001, 4'b0000};
        xw = 32'h079C32FD;
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; drive(32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            in_valid = (e < 4);
            drive((e < 4) ? (xw & (32'hFF << (8*e))) : 32'd0);
            @(posedge clk); #1;
            chk($sformatf("m1_e%0d_vld", e), {28'd0, vld1}, {28'd0, m1_ev[e]});
            chk($sformatf("m1_e%0d_done", e), {31'd0, done1}, {31'd0, (e == 7)});
            chk($sformatf("m1_e%0d_busy", e), {31'd0, busy1}, {31'd0, (e < 7)});
            if (e == 3) chk("m1_aligned_row", dout1_w, xw);
        end
`ifdef SKEW_BUF_STATS_EN
        chk("m1_stats_in", {16'd0, rin1}, 32'd4);
        chk("m1_stats_out", {16'd0, rout1}, 32'd4);
`endif
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("m1_done_once", {31'd0, done1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_skew_buf.md
Name: systolic_skew_buf

Overview:
Parametrised operand staging buffer for the systolic matrix-multiply array. It accepts one DIM-wide signed row per cycle and presents each lane with a lane-dependent delay, so the array sees diagonally skewed operands. In de-skew mode the same structure realigns skewed array outputs into rows. Per-lane valid tracking, stall, flush and drain-done signalling let the controller sequence back-to-back tiles without fixed cycle counting.

Parameters:
BITS_AB, 8, signed element width
DIM, 8, lane count and array dimension (>=2)
MODE, 0, 0 = skew (lane c delay c+1); 1 = de-skew (lane c delay DIM-c)
ZERO_INVALID, 1, 1 = output lanes carrying no valid data drive 0; 0 = they show stage contents unchanged

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  advance enable; 0 = full stall, all state held
in_valid  in  1  din holds a row to accept on this advancing edge
din  in  BITS_AB x DIM (signed, unpacked [DIM-1:0])  input row, element c goes to lane c
flush  in  1  synchronous clear of pipeline contents
dout  out  BITS_AB x DIM (signed, unpacked [DIM-1:0])  lane outputs
dout_vld  out  DIM  per-lane valid
busy  out  1  any valid data held in any stage
done  out  1  one-cycle pulse after the pipeline drains

Behaviour:
- Lane c: shift register of D(c) stages; D(c)=c+1 (MODE 0) or DIM-c (MODE 1); max depth DIM. Each stage holds data plus valid bit.
- Advancing edge = rising clk with en=1 and rst=0 and flush=0. Every lane shifts one stage. Stage 0 loads din[c] with valid=in_valid; in_valid=0 inserts a bubble (valid 0, data 0).
- en=0: no shift, no load, din ignored, outputs and FSM hold. in_valid with en=0 is ignored, not queued.
- Latency: a row accepted on advancing edge k appears on lane c after D(c) advancing edges, counting edge k as the first. dout/dout_vld are the last-stage registers; no combinational path from din.
- ZERO_INVALID=1: dout[c]=0 whenever dout_vld[c]=0.
- busy = OR of all stage valid bits; combinational from registers.
- FSM states IDLE, RUN, DRAIN:
  IDLE -> RUN on advancing edge with in_valid=1.
  RUN -> DRAIN on advancing edge with in_valid=0.
  DRAIN -> RUN on advancing edge with in_valid=1.
  DRAIN -> IDLE on the advancing edge that shifts out the last valid bit (all stage valids 0 after the edge).
  done registered, =1 for exactly one cycle after the DRAIN->IDLE edge. Held at 0 during stalls.
- Single row in MODE 0: done rises DIM advancing edges after the accept edge.
- flush=1 (en ignored): all stage data and valids cleared, FSM -> IDLE, done=0, no done pulse generated. flush with in_valid on the same edge: flush wins and the row is dropped.
- rst=1: all stages, dout, dout_vld, busy, done = 0; FSM = IDLE. Same when asserted mid-operation; rst dominates flush and en.
- Arithmetic: none; data passes bit-exact, signedness preserved.

Optional Feature:
Macro SKEW_BUF_STATS_EN. Defined: adds outputs rows_in[15:0] and rows_out[15:0]. rows_in increments on each accepted row. rows_out increments when the longest lane emits a valid element. Both saturate at 16'hFFFF and clear on rst or flush. Undefined: ports and counters do not exist; all other behaviour is identical.

Test Plan:
- DIM=4, MODE 0: rst two cycles, accept rows R0..R3 (R0={1,2,3,4}) on consecutive edges -> lane0 emits 1 one edge after accept, lane3 emits 4 four edges after accept, dout_vld walks 0001,0011,0111,1111,1110,1100,1000,0000; done pulses once, busy falls the same edge.
- MODE 1, DIM=4: feed already-skewed data (lane c valid c edges late) -> all four lanes show dout_vld=1111 on the same cycle and the row is realigned exactly.
- Stall: accept R0={-128,127,-1,0}, hold en=0 for 5 cycles mid-flight -> outputs and dout_vld frozen, no done; resume, and each element appears after its D(c) advancing edges with values preserved.
- Bubble: rows R0, gap, R1 -> bubble lanes show 0 with valid 0 (ZERO_INVALID=1); FSM RUN->DRAIN->RUN; a single done pulses only after R1 fully exits.
- Flush with in_valid=1 while 3 rows are in flight -> next cycle busy=0, dout_vld=0, dout=0, no done; the following accepted row behaves as from reset.
- rst mid-DRAIN -> all outputs 0 next cycle; with SKEW_BUF_STATS_EN defined, rows_in=rows_out=0 after rst, and rows_in=4, rows_out=4 after a clean 4-row run.
